// File: rtl/ram_2p_port_initiator_if.sv
// Host-side request/response channels of ram_2p_port_initiator.
// slave = initiator's view, master = host's view.
interface ram_2p_port_initiator_if #(
  parameter int unsigned Width = 32,
  parameter int unsigned Aw    = 7
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_write_i;
  logic [Aw-1:0]    req_addr_i;
  logic [Width-1:0] req_wdata_i;
  logic [Width-1:0] req_wmask_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [Width-1:0] rsp_rdata_o;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wmask_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wmask_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o
  );
endinterface

// File: rtl/ram_2p_port_initiator.sv
// Valid/ready initiator for one SRAM port: 1-cycle read latency, 2-entry response FIFO.
// Define RAM_2P_INITIATOR_INIT_EN to write InitValue to every word after each reset.
module ram_2p_port_initiator #(
  parameter int unsigned       Width     = 32,
  parameter int unsigned       Depth     = 128,
  parameter logic [Width-1:0]  InitValue = '0,
  localparam int unsigned      Aw        = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  ram_2p_port_initiator_if.slave    host,
  output logic                      ram_req_o,
  output logic                      ram_write_o,
  output logic [Aw-1:0]             ram_addr_o,
  output logic [Width-1:0]          ram_wdata_o,
  output logic [Width-1:0]          ram_wmask_o,
  input  logic [Width-1:0]          ram_rdata_i,
  output logic                      init_done_o
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

`ifdef RAM_2P_INITIATOR_INIT_EN
  localparam state_e ResetState = ST_INIT;
`else
  localparam state_e ResetState = ST_RUN;
`endif

  state_e           state_q, state_d;
  logic [Aw-1:0]    cnt_q, cnt_d;
  logic             open_q;
  logic             inflight_q;
  logic [Width-1:0] fifo_mem [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       occ;
  logic             req_ready, accept, push, pop;

  // Credit counts the in-flight read so a push can never find the FIFO full.
  assign occ    = count_q + {1'b0, inflight_q};
  assign push   = inflight_q;
  assign pop    = (count_q != 2'd0) && host.rsp_ready_i;
  assign accept = host.req_valid_i && req_ready;

  assign host.req_ready_o = req_ready;
  assign host.rsp_valid_o = (count_q != 2'd0);
  assign host.rsp_rdata_o = fifo_mem[rd_ptr_q];

`ifdef RAM_2P_INITIATOR_INIT_EN
  assign init_done_o = open_q;
`else
  assign init_done_o = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready   = 1'b0;
    ram_req_o   = 1'b0;
    ram_write_o = 1'b0;
    ram_addr_o  = host.req_addr_i;
    ram_wdata_o = host.req_wdata_i;
    ram_wmask_o = host.req_wmask_i;
    case (state_q)
      ST_INIT: begin
        // Gated by rst_ni so the reset cycles themselves issue no RAM traffic.
        ram_req_o   = rst_ni;
        ram_write_o = 1'b1;
        ram_addr_o  = cnt_q;
        ram_wdata_o = InitValue;
        ram_wmask_o = '1;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == Aw'(Depth - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        req_ready   = open_q && (occ < 2'd2);
        ram_req_o   = host.req_valid_i && req_ready;
        ram_write_o = host.req_write_i;
      end
      default: state_d = ResetState;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ResetState;
      cnt_q      <= '0;
      open_q     <= 1'b0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      open_q     <= (state_d == ST_RUN);
      inflight_q <= accept && !host.req_write_i;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= ram_rdata_i;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && !pop && (count_q == 2'd2)));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop && (count_q == 2'd0)));
  a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (count_q <= 2'd2));
  a_no_req_before_done: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(ram_req_o && !init_done_o && (state_q != ST_INIT)));

endmodule
